// File: rtl/morse_pkg.sv
// Shared definitions for the Morse timing decoder and its downstream stages.
//   SYM_*   : 2-bit symbol codes carried on sym_code
//   state_e : run-length classifier states
package morse_pkg;

    localparam logic [1:0] SYM_DOT  = 2'b01;
    localparam logic [1:0] SYM_DASH = 2'b10;
    localparam logic [1:0] SYM_LGAP = 2'b11;
    localparam logic [1:0] SYM_WGAP = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2,
        ERR   = 2'd3
    } state_e;

endpackage

// File: rtl/morse_sym_hold.sv
// One-entry valid/ready holding register with overflow detection.
// A pushed item is loaded when the register is empty or being drained in the
// same cycle; otherwise it is dropped and o_ovf pulses for one cycle.
//   clk, reset : clock, asynchronous active-low reset
//   i_push     : a new item is offered this cycle
//   i_data     : the offered item
//   i_ready    : consumer accepts the held item when o_valid && i_ready
//   o_valid    : register holds an item
//   o_data     : held item, stable while o_valid && !i_ready
//   o_ovf      : one-cycle pulse, an offered item was dropped
module morse_sym_hold #(
    parameter int unsigned DATA_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_ovf
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_ovf;
    logic              w_load;
    logic              w_drop;

    // Draining and loading in the same cycle keeps the register full (no bubble).
    assign w_load = i_push && (!r_valid || i_ready);
    assign w_drop = i_push && r_valid && !i_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent behaviour.
    // NOTE: the data register is reset as well, because sym_code must read 00
    // out of reset even though it is only meaningful while valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_ovf <= w_drop;
            if (w_load) begin
                r_valid <= 1'b1;
                r_data  <= i_data;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_ovf   = r_ovf;

endmodule

// File: rtl/morse_timing_decoder.sv
// Morse run-length classifier. Mark/space runs on in_tx are measured in
// sample ticks and classified as dot, dash, letter gap or word gap; symbols
// leave through a one-entry valid/ready register.
//   clk, reset : clock, asynchronous active-low reset
//   tick       : sample strobe, in_tx is only evaluated when tick=1
//   in_tx      : sampled line level (1 = mark)
//   sym_valid  : output register holds a symbol
//   sym_code   : 01 dot, 10 dash, 11 letter gap, 00 word gap
//   sym_ready  : consumer handshake
//   ovf        : one-cycle pulse, symbol dropped because output was full
//   err_long   : one-cycle pulse, mark reached MARK_MAX
module morse_timing_decoder
    import morse_pkg::*;
#(
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned DASH_MIN       = 3,
    parameter int unsigned LETTER_GAP_MIN = 3,
    parameter int unsigned WORD_GAP_MIN   = 7,
    parameter int unsigned MARK_MAX       = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       in_tx,
    output logic       sym_valid,
    output logic [1:0] sym_code,
    input  logic       sym_ready,
    output logic       ovf,
    output logic       err_long
);

    // Thresholds are compared against cnt+1, which is one bit wider than cnt.
    localparam logic [CNT_W:0]   C_MARK_MAX = (CNT_W+1)'(MARK_MAX);
    localparam logic [CNT_W:0]   C_LGAP_MIN = (CNT_W+1)'(LETTER_GAP_MIN);
    localparam logic [CNT_W:0]   C_WGAP_MIN = (CNT_W+1)'(WORD_GAP_MIN);
    localparam logic [CNT_W-1:0] C_DASH_MIN = CNT_W'(DASH_MIN);
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W:0]   w_cnt_inc;
    logic [CNT_W-1:0] w_cnt_sat;
    logic             r_err_long;
    logic             w_err;
    logic             w_emit;
    logic [1:0]       w_emit_code;

    // Saturating increment: the carry bit signals the counter is already full.
    assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign w_cnt_sat = w_cnt_inc[CNT_W] ? r_cnt : w_cnt_inc[CNT_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_err_long <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_err_long <= w_err;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err       = 1'b0;
        w_emit      = 1'b0;
        w_emit_code = SYM_DOT;
        if (tick) begin
            unique case (r_state)
                IDLE: begin
                    if (in_tx) begin
                        w_state_nxt = MARK;
                        w_cnt_nxt   = C_ONE;
                    end
                end
                MARK: begin
                    if (in_tx) begin
                        w_cnt_nxt = w_cnt_sat;
                        if (w_cnt_inc == C_MARK_MAX) begin
                            w_err       = 1'b1;
                            w_state_nxt = ERR;
                        end
                    end else begin
                        w_emit      = 1'b1;
                        w_emit_code = (r_cnt < C_DASH_MIN) ? SYM_DOT : SYM_DASH;
                        w_state_nxt = SPACE;
                        w_cnt_nxt   = C_ONE;
                    end
                end
                SPACE: begin
                    if (in_tx) begin
                        w_state_nxt = MARK;
                        w_cnt_nxt   = C_ONE;
                    end else begin
                        w_cnt_nxt = w_cnt_sat;
                        if (w_cnt_inc == C_LGAP_MIN) begin
                            w_emit      = 1'b1;
                            w_emit_code = SYM_LGAP;
                        end else if (w_cnt_inc == C_WGAP_MIN) begin
                            w_emit      = 1'b1;
                            w_emit_code = SYM_WGAP;
                            w_state_nxt = IDLE;
                            w_cnt_nxt   = '0;
                        end
                    end
                end
                ERR: begin
                    // Wait for the over-long mark to end before listening again.
                    if (!in_tx) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    morse_sym_hold #(
        .DATA_W (2)
    ) u_hold (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_emit),
        .i_data  (w_emit_code),
        .i_ready (sym_ready),
        .o_valid (sym_valid),
        .o_data  (sym_code),
        .o_ovf   (ovf)
    );

    assign err_long = r_err_long;

endmodule
